// File: rtl/pix_hfilt3.sv
// pix_hfilt3: 3-tap horizontal [1 2 1]/4 smoothing filter on ARGB8888 pixels.
// R, G and B are filtered; A passes through from the centre pixel. The left
// neighbour of pixel 0 and the right neighbour of the last pixel in a line
// are replaced by the centre pixel. Line and frame boundaries come only from
// the pixel counters, so gaps in vin never break the filter history.
//
// Valid semantics: din is consumed on every rising edge where vin=1 (there
// is no backpressure). vout=1 marks one filtered pixel on dout for exactly
// that cycle. While vout=0, dout keeps its previous value.
//
// Output timing: a pixel with a right neighbour in the same line is emitted
// on the edge that samples that neighbour. The last pixel of a line is
// emitted on the following edge (the pending flush), whether or not vin is
// high on that edge. When the next line's pixel 0 arrives on the flush edge,
// only the flush is emitted. Pixel 0 never produces output on its own sample
// edge, so the flush and a mid-line output can never collide.
module pix_hfilt3 #(
  parameter int H_WIDTH = 2448,
  parameter int V_WIDTH = 2048,
  parameter int BYPASS  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vin,
  input  logic [31:0] din,
  output logic        vout,
  output logic [31:0] dout,
  output logic        frm_done
);

  localparam int HCW = (H_WIDTH > 1) ? $clog2(H_WIDTH) : 1;
  localparam int VCW = (V_WIDTH > 1) ? $clog2(V_WIDTH) : 1;

  localparam logic [HCW-1:0] H_LAST = HCW'(H_WIDTH - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_WIDTH - 1);

  // Position of the pixel being sampled this cycle.
  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;

  // Pixel history. c_pix is the newest sampled pixel, which waits for its
  // right neighbour. l_pix is its left neighbour; for pixel 0 it is loaded
  // with the pixel itself, which implements the left-edge rule directly.
  logic [31:0] l_pix;
  logic [31:0] c_pix;

  // Pending flush of the last pixel of a line, and whether that pixel also
  // closes the frame.
  logic pend;
  logic pend_frm;

  logic h_last;
  logic v_last;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // One colour channel: (L + 2C + R + 2) >> 2 in a 10-bit sum. The largest
  // sum is 1022, so the 8-bit result never needs saturation.
  function automatic logic [7:0] tap3(input logic [7:0] l,
                                      input logic [7:0] c,
                                      input logic [7:0] r);
    logic [9:0] sum;
    sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 10'd2;
    return sum[9:2];
  endfunction

  // Full ARGB output for one centre pixel; alpha comes from the centre.
  function automatic logic [31:0] pix_out(input logic [31:0] l,
                                          input logic [31:0] c,
                                          input logic [31:0] r);
    logic [31:0] res;
    if (BYPASS != 0) begin
      res = c;
    end else begin
      res = {c[31:24],
             tap3(l[23:16], c[23:16], r[23:16]),
             tap3(l[15:8],  c[15:8],  r[15:8]),
             tap3(l[7:0],   c[7:0],   r[7:0])};
    end
    return res;
  endfunction

  // Pixel/line counters: advance only on sampled pixels, wrapping at the
  // line and frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (vin) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + VCW'(1);
      end else begin
        hcnt <= hcnt + HCW'(1);
      end
    end
  end

  // History, pending flush and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_pix    <= '0;
      c_pix    <= '0;
      pend     <= 1'b0;
      pend_frm <= 1'b0;
      vout     <= 1'b0;
      dout     <= '0;
      frm_done <= 1'b0;
    end else begin
      vout     <= 1'b0;
      frm_done <= 1'b0;

      // Flush the last pixel of the previous line using R = C.
      if (pend) begin
        vout     <= 1'b1;
        dout     <= pix_out(l_pix, c_pix, c_pix);
        frm_done <= pend_frm;
        pend     <= 1'b0;
      end

      if (vin) begin
        if (hcnt == '0) begin
          // First pixel of a line: start a fresh history with L = C.
          l_pix <= din;
          c_pix <= din;
        end else begin
          // The new pixel is the right neighbour of the waiting centre.
          vout  <= 1'b1;
          dout  <= pix_out(l_pix, c_pix, din);
          l_pix <= c_pix;
          c_pix <= din;
        end
        // The last pixel of a line has no right neighbour; flush next edge.
        if (h_last) begin
          pend     <= 1'b1;
          pend_frm <= v_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pix_hfilt3.sv
// tb_pix_hfilt3: directed checks of pix_hfilt3 with three instances sharing
// one stimulus stream: filtering (H=4,V=2), bypass (H=4,V=2,BYPASS=1) and
// single-pixel lines (H=1,V=2). The first two are checked against a
// hand-computed vector table; the H=1 instance against a one-cycle-delay
// model. A final sequence inserts random-length gaps inside a line.
module tb_pix_hfilt3;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [31:0] din = '0;

  always #5 clk = ~clk;

  logic        vout_m, frm_m;
  logic [31:0] dout_m;
  logic        vout_b, frm_b;
  logic [31:0] dout_b;
  logic        vout_1, frm_1;
  logic [31:0] dout_1;

  pix_hfilt3 #(.H_WIDTH(4), .V_WIDTH(2), .BYPASS(0)) dut_m (
    .clk(clk), .rst(rst), .vin(vin), .din(din),
    .vout(vout_m), .dout(dout_m), .frm_done(frm_m)
  );

  pix_hfilt3 #(.H_WIDTH(4), .V_WIDTH(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .vin(vin), .din(din),
    .vout(vout_b), .dout(dout_b), .frm_done(frm_b)
  );

  pix_hfilt3 #(.H_WIDTH(1), .V_WIDTH(2), .BYPASS(0)) dut_1 (
    .clk(clk), .rst(rst), .vin(vin), .din(din),
    .vout(vout_1), .dout(dout_1), .frm_done(frm_1)
  );

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [31:0] hold_m = '0;
  logic [31:0] hold_b = '0;
  logic [31:0] hold_1 = '0;
  // H=1 model: pixel sampled last edge, its frame-end flag, line parity.
  logic        p_v = 1'b0;
  logic [31:0] p_d = '0;
  logic        p_f = 1'b0;
  logic        vl  = 1'b0;

  typedef struct {
    logic        r;
    logic        v;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic        ef;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] px(input logic [7:0] b);
    return {8'h11, 8'h22, 8'h33, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [31:0] d,
                     input logic ev, input logic [31:0] ed, input logic ef,
                     input logic [31:0] eb);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.ev = ev; e.ed = ed; e.ef = ef; e.eb = eb;
    tbl.push_back(e);
  endtask

  // Driver: apply one cycle of inputs, then check all three instances.
  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic ev, input logic [31:0] ed, input logic ef,
                      input logic [31:0] eb);
    logic e1v;
    logic e1f;
    @(negedge clk);
    rst = r;
    vin = v;
    din = d;
    @(posedge clk);
    #1;
    if (r) begin
      hold_m = '0;
      hold_b = '0;
      hold_1 = '0;
      e1v = 1'b0;
      e1f = 1'b0;
      p_v = 1'b0;
      vl  = 1'b0;
    end else begin
      if (ev) begin
        hold_m = ed;
        hold_b = eb;
      end
      e1v = p_v;
      e1f = p_v & p_f;
      if (p_v) hold_1 = p_d;
      p_v = v;
      p_d = d;
      if (v) begin
        p_f = vl;
        vl  = ~vl;
      end
    end
    chk("filt_vout", 32'(vout_m), 32'(ev));
    chk("filt_dout", dout_m, hold_m);
    chk("filt_frm",  32'(frm_m),  32'(ef));
    chk("byp_vout",  32'(vout_b), 32'(ev));
    chk("byp_dout",  dout_b, hold_b);
    chk("byp_frm",   32'(frm_b),  32'(ef));
    chk("h1_vout",   32'(vout_1), 32'(e1v));
    chk("h1_dout",   dout_1, hold_1);
    chk("h1_frm",    32'(frm_1),  32'(e1f));
  endtask

  localparam logic [31:0] Q0 = 32'hA5_00_80_FF;
  localparam logic [31:0] Q2 = 32'hA5_01_80_FE;

  logic [7:0] bv [4];
  logic [7:0] fv [4];

  initial begin
    // Reset with vin high: vin must be ignored.
    add(1, 1, px(8'd99),  0, '0, 0, '0);
    // Contiguous line 0: B 0,40,80,120 -> 10,40,80,110.
    add(0, 1, px(8'd0),   0, '0, 0, '0);
    add(0, 1, px(8'd40),  1, px(8'd10),  0, px(8'd0));
    add(0, 1, px(8'd80),  1, px(8'd40),  0, px(8'd40));
    add(0, 1, px(8'd120), 1, px(8'd80),  0, px(8'd80));
    add(0, 0, '0,         1, px(8'd110), 0, px(8'd120));
    add(0, 0, '0,         0, '0, 0, '0);
    // Line 1 with a 3-cycle gap between pixels 1 and 2; frame ends.
    add(0, 1, px(8'd0),   0, '0, 0, '0);
    add(0, 1, px(8'd40),  1, px(8'd10),  0, px(8'd0));
    add(0, 0, '0,         0, '0, 0, '0);
    add(0, 0, '0,         0, '0, 0, '0);
    add(0, 0, '0,         0, '0, 0, '0);
    add(0, 1, px(8'd80),  1, px(8'd40),  0, px(8'd40));
    add(0, 1, px(8'd120), 1, px(8'd80),  0, px(8'd80));
    add(0, 0, '0,         1, px(8'd110), 1, px(8'd120));
    add(0, 0, '0,         0, '0, 0, '0);
    // Back-to-back lines B=100 then B=0: no blending across the boundary.
    add(0, 1, px(8'd100), 0, '0, 0, '0);
    add(0, 1, px(8'd100), 1, px(8'd100), 0, px(8'd100));
    add(0, 1, px(8'd100), 1, px(8'd100), 0, px(8'd100));
    add(0, 1, px(8'd100), 1, px(8'd100), 0, px(8'd100));
    add(0, 1, px(8'd0),   1, px(8'd100), 0, px(8'd100));
    add(0, 1, px(8'd0),   1, px(8'd0),   0, px(8'd0));
    add(0, 1, px(8'd0),   1, px(8'd0),   0, px(8'd0));
    add(0, 1, px(8'd0),   1, px(8'd0),   0, px(8'd0));
    add(0, 0, '0,         1, px(8'd0),   1, px(8'd0));
    // Extremes: B 255,255,254,254 and R 0,0,1,1; alpha A5 passes through.
    add(0, 1, Q0, 0, '0, 0, '0);
    add(0, 1, Q0, 1, Q0, 0, Q0);
    add(0, 1, Q2, 1, Q0, 0, Q0);
    add(0, 1, Q2, 1, Q2, 0, Q2);
    add(0, 0, '0, 1, Q2, 0, Q2);
    // Partial line 1, then reset after pixel 2 (vin high on the reset edge).
    add(0, 1, px(8'd0),   0, '0, 0, '0);
    add(0, 1, px(8'd40),  1, px(8'd10),  0, px(8'd0));
    add(0, 1, px(8'd80),  1, px(8'd40),  0, px(8'd40));
    add(1, 1, px(8'd200), 0, '0, 0, '0);
    add(0, 0, '0,         0, '0, 0, '0);
    // Fresh line 0 after reset: B 200,100,0,60 -> 175,100,40,45, no frm.
    add(0, 1, px(8'd200), 0, '0, 0, '0);
    add(0, 1, px(8'd100), 1, px(8'd175), 0, px(8'd200));
    add(0, 1, px(8'd0),   1, px(8'd100), 0, px(8'd100));
    add(0, 1, px(8'd60),  1, px(8'd40),  0, px(8'd0));
    add(0, 0, '0,         1, px(8'd45),  0, px(8'd60));
    // Line 1 closes the frame, proving vcnt restarted at 0.
    add(0, 1, px(8'd0),   0, '0, 0, '0);
    add(0, 1, px(8'd40),  1, px(8'd10),  0, px(8'd0));
    add(0, 1, px(8'd80),  1, px(8'd40),  0, px(8'd40));
    add(0, 1, px(8'd120), 1, px(8'd80),  0, px(8'd80));
    add(0, 0, '0,         1, px(8'd110), 1, px(8'd120));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].eb);
    end

    // Random gaps inside line 0, contiguous line 1: history must survive.
    bv[0] = 8'd0;  bv[1] = 8'd40; bv[2] = 8'd80; bv[3] = 8'd120;
    fv[0] = 8'd10; fv[1] = 8'd40; fv[2] = 8'd80; fv[3] = 8'd110;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 4; i++) begin
        int g;
        g = (l == 0) ? int'($urandom_range(0, 3)) : 0;
        repeat (g) step(0, 0, '0, 0, '0, 0, '0);
        step(0, 1, px(bv[i]), (i > 0),
             (i > 0) ? px(fv[i-1]) : 32'h0, 0,
             (i > 0) ? px(bv[i-1]) : 32'h0);
      end
      step(0, 0, '0, 1, px(fv[3]), (l == 1), px(bv[3]));
    end
    step(0, 0, '0, 0, '0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pix_hfilt3.md
PIX_HFILT3 -- requirements
Module: pix_hfilt3

Interface
REQ-001 Parameter H_WIDTH, default 2448: pixels per line, which is also the line-boundary count.
REQ-002 Parameter V_WIDTH, default 2048: lines per frame, which is also the frame-boundary count.
REQ-003 Parameter BYPASS, default 0: when 1, dout is the unfiltered centre pixel with identical timing.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 vin  input  1  input pixel valid; the upstream VSYNC&HSYNC qualifier.
REQ-007 din  input  32  input pixel: [31:24] A, [23:16] R, [15:8] G, [7:0] B.
REQ-008 vout  output  1  output pixel valid; drives the downstream writer enable.
REQ-009 dout  output  32  filtered output pixel.
REQ-010 frm_done  output  1  one-cycle pulse with the last pixel of each frame.

Function
REQ-011 The block SHALL sample din only on clock edges where vin=1; vin=0 cycles are gaps and SHALL NOT alter pixel history.
REQ-012 An input pixel counter hcnt (0..H_WIDTH-1) SHALL increment on each sampled pixel and wrap to 0 after H_WIDTH-1; line boundaries come only from hcnt, never from vin gaps.
REQ-013 A line counter vcnt (0..V_WIDTH-1) SHALL increment on each line wrap and wrap to 0 after V_WIDTH-1.
REQ-014 Each of R, G and B SHALL be computed as (L + 2*C + R + 2) >> 2 using a 10-bit intermediate; the result SHALL be 8-bit with no saturation logic, since the maximum result is 255.
REQ-015 A SHALL pass through from the centre pixel unfiltered.
REQ-016 Left-edge rule: for hcnt=0 the centre pixel SHALL be L=C.
REQ-017 Right-edge rule: for hcnt=H_WIDTH-1 the centre pixel SHALL be R=C.
REQ-018 With H_WIDTH=1, every output SHALL equal its input.
REQ-019 The output for a non-last pixel i SHALL be registered on the edge that samples pixel i+1 of the same line.
REQ-020 The output for the last pixel of a line SHALL be registered on the clock edge after that pixel is sampled, regardless of vin on that edge.
REQ-021 A pending-flush flag SHALL hold the last pixel for one cycle; when the next line's pixel 0 arrives on the flush edge, the flush SHALL be output and pixel 0 SHALL be stored, producing no output for pixel 0 on that edge.
REQ-022 There SHALL be exactly one output per input pixel, in input order, with at most one output per cycle.
REQ-023 For a contiguous stream (vin high for the whole line), vout SHALL equal vin delayed by exactly one clock.
REQ-024 For gapped input, vout for non-last pixels SHALL stretch with the gaps.
REQ-025 vout=0 cycles SHALL hold dout at its last value.
REQ-026 frm_done SHALL assert in the same cycle as vout for pixel (H_WIDTH-1) of line (V_WIDTH-1), and be 0 otherwise.
REQ-027 An intra-line gap SHALL NOT trigger an edge rule; the filter SHALL continue across the gap with the pixel history intact.

Reset
REQ-028 While rst=1 the block SHALL hold vout=0, dout=32'h0, frm_done=0, hcnt=0, vcnt=0, the pending flag at 0, and pixel history at 0.
REQ-029 Reset asserted mid-line SHALL discard the partial line and pending flush with no output on the reset edge; the first sampled pixel after reset release SHALL be treated as hcnt=0, vcnt=0.
REQ-030 vin while rst=1 SHALL be ignored.

Verification
REQ-031 H_WIDTH=4, V_WIDTH=2, contiguous B bytes 0,40,80,120 -> vout one cycle after vin; B out 10,40,80,110; A, R and G unchanged when constant.
REQ-032 Same stream with a 3-cycle gap between pixels 1 and 2 -> outputs identical to REQ-031; pixel 1 output delayed until pixel 2 is sampled; the last pixel is output the edge after its sample.
REQ-033 Two lines back-to-back with no vin gap (line 0 B=100 constant, line 1 B=0 constant) -> line 0 all 100 and line 1 all 0, with no blending across the boundary; frm_done high with the 8th output only.
REQ-034 Inputs L=255, C=255, R=254 -> (255+510+254+2)>>2 = 255; inputs L=0, C=0, R=1 -> 0; no overflow; A byte 8'hA5 passes through.
REQ-035 Reset asserted after pixel 2 of line 0, then a fresh 4-pixel line -> no stale outputs; first output is pixel 0 of the new line with the left-edge rule; vcnt restarts at 0.
REQ-036 BYPASS=1 run of REQ-031 -> dout equals din, vout timing identical, frm_done timing identical.
